// File: rtl/spi_slave_if.sv
// Byte handshake between the SPI slave engine and the peripheral's TX/RX FIFOs.
interface spi_slave_if;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_pop_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;

    modport slave  (input  tx_data_i, tx_valid_i, output tx_pop_o, rx_data_o, rx_valid_o);
    modport master (output tx_data_i, tx_valid_i, input  tx_pop_o, rx_data_o, rx_valid_o);
endinterface

// File: rtl/spi_slave.sv
// Single-lane SPI slave: oversamples SCLK/SS/MOSI with clk_i, shifts TX FIFO bytes onto MISO
// and pushes received MOSI bytes to the RX FIFO.
//   state    | meaning
//   ST_IDLE  | deselected or disabled; MISO tristated
//   ST_LOAD  | one cycle after a byte load (first bit already on MISO)
//   ST_SHIFT | sampling MOSI / shifting MISO on SCLK edges
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [1:0] cp_mode_i,
    input  logic       msb_first_i,
    spi_slave_if.slave fifo,
    output logic       underrun_o,
    output logic       busy_o,
    input  logic       spi_clk_i,
    input  logic       spi_ss_i,
    input  logic       spi_dq0_i,
    output logic       spi_dq1_o,
    output logic       spi_dq1_oe_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] dq0_sync_q, dq0_sync_d;
    logic [SYNC_STAGES-1:0] init_q, init_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ss_prev_q, ss_prev_d;
    logic                   arm_q, arm_d;
    state_e                 state_q, state_d;
    logic [7:0]             tx_shreg_q, tx_shreg_d;
    logic [7:0]             rx_shreg_q, rx_shreg_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_pop_q, tx_pop_d;
    logic                   underrun_q, underrun_d;

    logic sclk_s, ss_s, dq0_s;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic ss_fall, start, load;
    logic [7:0] rx_next;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign dq0_s  = dq0_sync_q[SYNC_STAGES-1];

    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign lead_edge   = cp_mode_i[1] ? sclk_fall : sclk_rise;
    assign trail_edge  = cp_mode_i[1] ? sclk_rise : sclk_fall;
    assign sample_edge = cp_mode_i[0] ? trail_edge : lead_edge;
    assign shift_edge  = cp_mode_i[0] ? lead_edge : trail_edge;

    // A start needs SS to have been seen high from real samples while enabled, so SS held
    // low through reset release or enable rise is not mistaken for a falling edge.
    assign ss_fall = ~ss_s & ss_prev_q;
    assign start   = ss_fall & arm_q & enable_i;
    assign rx_next = msb_first_i ? {rx_shreg_q[6:0], dq0_s} : {dq0_s, rx_shreg_q[7:1]};

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_i};
        dq0_sync_d  = {dq0_sync_q[SYNC_STAGES-2:0], spi_dq0_i};
        init_d      = {init_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;
        arm_d       = enable_i & (arm_q | (init_q[SYNC_STAGES-1] & ss_s));

        state_d    = state_q;
        tx_shreg_d = tx_shreg_q;
        rx_shreg_d = rx_shreg_q;
        bit_cnt_d  = bit_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_pop_d   = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    load    = 1'b1;
                end
            end
            ST_LOAD: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (sample_edge) begin
                    rx_shreg_d = rx_next;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        state_d    = ST_LOAD;
                        load       = 1'b1;
                    end
                end else if (shift_edge && bit_cnt_q != 3'd0) begin
                    tx_shreg_d = msb_first_i ? {tx_shreg_q[6:0], 1'b1} : {1'b1, tx_shreg_q[7:1]};
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The load happens on entry to ST_LOAD so pop/underrun pulse during the LOAD cycle.
        if (load) begin
            tx_shreg_d = fifo.tx_valid_i ? fifo.tx_data_i : 8'hFF;
            tx_pop_d   = fifo.tx_valid_i;
            underrun_d = ~fifo.tx_valid_i;
            bit_cnt_d  = 3'd0;
        end

        if (state_q != ST_IDLE && (ss_s || !enable_i)) begin
            state_d    = ST_IDLE;
            tx_shreg_d = tx_shreg_q;
            rx_shreg_d = 8'h00;
            bit_cnt_d  = 3'd0;
            rx_data_d  = rx_data_q;
            rx_valid_d = 1'b0;
            tx_pop_d   = 1'b0;
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            dq0_sync_q  <= '0;
            init_q      <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            arm_q       <= 1'b0;
            state_q     <= ST_IDLE;
            tx_shreg_q  <= 8'h00;
            rx_shreg_q  <= 8'h00;
            bit_cnt_q   <= 3'd0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_pop_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            dq0_sync_q  <= dq0_sync_d;
            init_q      <= init_d;
            sclk_prev_q <= sclk_prev_d;
            ss_prev_q   <= ss_prev_d;
            arm_q       <= arm_d;
            state_q     <= state_d;
            tx_shreg_q  <= tx_shreg_d;
            rx_shreg_q  <= rx_shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_pop_q    <= tx_pop_d;
            underrun_q  <= underrun_d;
        end
    end

    assign busy_o          = (state_q != ST_IDLE);
    assign spi_dq1_oe_o    = busy_o;
    assign spi_dq1_o       = busy_o & (msb_first_i ? tx_shreg_q[7] : tx_shreg_q[0]);
    assign underrun_o      = underrun_q;
    assign fifo.tx_pop_o   = tx_pop_q;
    assign fifo.rx_data_o  = rx_data_q;
    assign fifo.rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-level SPI master plus a FIFO model, with expected
// bytes derived from the transfer description (TX queue contents, 0xFF on underrun).
module tb_spi_slave;
    localparam int H = 8;  // clk_i cycles per SCLK half period

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       enable_i = 1'b0;
    logic [1:0] cp_mode_i = 2'b00;
    logic       msb_first_i = 1'b1;
    logic       underrun_o, busy_o;
    logic       spi_clk_i = 1'b0;
    logic       spi_ss_i = 1'b1;
    logic       spi_dq0_i = 1'b0;
    logic       spi_dq1_o, spi_dq1_oe_o;

    spi_slave_if fifo ();

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .cp_mode_i(cp_mode_i),
        .msb_first_i(msb_first_i), .fifo(fifo), .underrun_o(underrun_o), .busy_o(busy_o),
        .spi_clk_i(spi_clk_i), .spi_ss_i(spi_ss_i), .spi_dq0_i(spi_dq0_i),
        .spi_dq1_o(spi_dq1_o), .spi_dq1_oe_o(spi_dq1_oe_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] tx_mem [16];
    int         tx_wr = 0;
    int         tx_rd = 0;
    logic [7:0] rx_mem [16];
    int         rx_cnt = 0;
    int         pop_cnt = 0;
    int         und_cnt = 0;

    // TX FIFO model and output monitor, sampled away from the active edge.
    always @(negedge clk_i) begin
        if (fifo.tx_pop_o === 1'b1) begin
            pop_cnt++;
            tx_rd++;
        end
        if (fifo.rx_valid_o === 1'b1) begin
            rx_mem[rx_cnt % 16] = fifo.rx_data_o;
            rx_cnt++;
        end
        if (underrun_o === 1'b1) und_cnt++;
        fifo.tx_valid_i = (tx_wr != tx_rd);
        fifo.tx_data_i  = (tx_wr != tx_rd) ? tx_mem[tx_rd % 16] : 8'h00;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] exp_miso(input int i, input int fill, input logic [7:0] b [4]);
        return (i < fill) ? b[i] : 8'hFF;
    endfunction

    task automatic load_fifo(input int fill, input logic [7:0] b [4]);
        for (int k = 0; k < fill; k++) begin
            tx_mem[tx_wr % 16] = b[k];
            tx_wr++;
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic flush_fifo();
        tx_wr = tx_rd;
        repeat (2) @(negedge clk_i);
    endtask

    // Bit-level SPI master; reports MISO bytes, busy fall latency and oe samples off expectation.
    task automatic spi_xfer(input logic [1:0] mode, input logic msb, input int nbits,
                            input logic exp_active, input logic hold_ss,
                            input logic [7:0] mosi [4], output logic [7:0] miso [4],
                            output int lat, output int oe_bad);
        logic cpol, cpha;
        cpol = mode[1];
        cpha = mode[0];
        oe_bad = 0;
        lat = 0;
        for (int b = 0; b < 4; b++) miso[b] = 8'h00;
        @(negedge clk_i);
        cp_mode_i = mode;
        msb_first_i = msb;
        spi_clk_i = cpol;
        repeat (2 * H) @(negedge clk_i);
        spi_ss_i = 1'b0;
        repeat (H) @(negedge clk_i);
        for (int i = 0; i < nbits; i++) begin
            int by;
            int pos;
            by = i / 8;
            pos = msb ? 7 - (i % 8) : (i % 8);
            if (!cpha) begin
                spi_dq0_i = mosi[by][pos];
                repeat (H) @(negedge clk_i);
                miso[by][pos] = spi_dq1_o;
                if (spi_dq1_oe_o !== exp_active) oe_bad++;
                spi_clk_i = ~cpol;
                repeat (H) @(negedge clk_i);
                spi_clk_i = cpol;
            end else begin
                spi_clk_i = ~cpol;
                spi_dq0_i = mosi[by][pos];
                repeat (H) @(negedge clk_i);
                miso[by][pos] = spi_dq1_o;
                if (spi_dq1_oe_o !== exp_active) oe_bad++;
                spi_clk_i = cpol;
                repeat (H) @(negedge clk_i);
            end
        end
        repeat (H) @(negedge clk_i);
        if (!hold_ss) begin
            spi_ss_i = 1'b1;
            while (busy_o !== 1'b0 && lat < 20) begin
                @(negedge clk_i);
                lat++;
            end
            repeat (H) @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy_o, spi_dq1_oe_o, spi_dq1_o, fifo.tx_pop_o, fifo.rx_valid_o, underrun_o, fifo.rx_data_o} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b oe=%b dq1=%b pop=%b rxv=%b und=%b rxd=%h, exp all 0",
                     busy_o, spi_dq1_oe_o, spi_dq1_o, fifo.tx_pop_o, fifo.rx_valid_o, underrun_o, fifo.rx_data_o);
        end
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        enable_i = 1'b1;
        repeat (10) @(negedge clk_i);
        n_checks++;
        if ({busy_o, spi_dq1_oe_o, fifo.tx_pop_o, fifo.rx_valid_o, underrun_o} !== 5'h0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy=%b oe=%b pop=%b rxv=%b und=%b, exp all 0",
                     busy_o, spi_dq1_oe_o, fifo.tx_pop_o, fifo.rx_valid_o, underrun_o);
        end
    endtask

    task automatic test_mode0_basic();
        logic [7:0] txb [4];
        logic [7:0] mo [4];
        logic [7:0] mi [4];
        int p0, u0, r0, lat, oeb;
        txb = '{8'hA5, 8'h00, 8'h00, 8'h00};
        mo  = '{8'h3C, 8'h00, 8'h00, 8'h00};
        load_fifo(1, txb);
        p0 = pop_cnt; u0 = und_cnt; r0 = rx_cnt;
        spi_xfer(2'b00, 1'b1, 8, 1'b1, 1'b0, mo, mi, lat, oeb);
        n_checks++;
        if (mi[0] !== 8'hA5) begin n_fail++; $display("FAIL m0_miso: got %h exp a5", mi[0]); end
        n_checks++;
        if (rx_cnt - r0 != 1 || rx_mem[r0 % 16] !== 8'h3C) begin
            n_fail++; $display("FAIL m0_rx: got %0d pushes first=%h, exp 1 push of 3c", rx_cnt - r0, rx_mem[r0 % 16]);
        end
        n_checks++;
        if (pop_cnt - p0 != 1) begin n_fail++; $display("FAIL m0_pops: got %0d exp 1", pop_cnt - p0); end
        n_checks++;
        if (und_cnt - u0 != 1) begin n_fail++; $display("FAIL m0_underrun_reload: got %0d exp 1", und_cnt - u0); end
        n_checks++;
        if (lat < 2 || lat > 3) begin n_fail++; $display("FAIL m0_busy_fall: got %0d clk exp 2..3", lat); end
        n_checks++;
        if (oeb != 0) begin n_fail++; $display("FAIL m0_oe_active: got %0d bad samples exp 0", oeb); end
        n_checks++;
        if ({busy_o, spi_dq1_oe_o} !== 2'b00) begin
            n_fail++; $display("FAIL m0_idle_after: got busy=%b oe=%b exp 0 0", busy_o, spi_dq1_oe_o);
        end
        flush_fifo();
    endtask

    task automatic test_mode3_back_to_back();
        logic [7:0] txb [4];
        logic [7:0] mo [4];
        logic [7:0] mi [4];
        int p0, r0, lat, oeb;
        txb = '{8'h01, 8'h80, 8'h00, 8'h00};
        mo  = '{8'hF0, 8'h0F, 8'h00, 8'h00};
        load_fifo(2, txb);
        p0 = pop_cnt; r0 = rx_cnt;
        spi_xfer(2'b11, 1'b0, 16, 1'b1, 1'b0, mo, mi, lat, oeb);
        n_checks++;
        if (mi[0] !== 8'h01 || mi[1] !== 8'h80) begin
            n_fail++; $display("FAIL m3_miso: got %h %h exp 01 80", mi[0], mi[1]);
        end
        n_checks++;
        if (rx_cnt - r0 != 2 || rx_mem[r0 % 16] !== 8'hF0 || rx_mem[(r0 + 1) % 16] !== 8'h0F) begin
            n_fail++; $display("FAIL m3_rx: got %0d pushes %h %h exp 2 pushes f0 0f",
                               rx_cnt - r0, rx_mem[r0 % 16], rx_mem[(r0 + 1) % 16]);
        end
        n_checks++;
        if (pop_cnt - p0 != 2) begin n_fail++; $display("FAIL m3_pops: got %0d exp 2", pop_cnt - p0); end
        flush_fifo();
    endtask

    task automatic test_modes_1_2();
        logic [7:0] txb [4];
        logic [7:0] mo [4];
        logic [7:0] mi [4];
        int r0, lat, oeb;
        txb = '{8'h5A, 8'h00, 8'h00, 8'h00};
        mo  = '{8'hC3, 8'h00, 8'h00, 8'h00};
        for (int m = 1; m <= 2; m++) begin
            load_fifo(1, txb);
            r0 = rx_cnt;
            spi_xfer(m[1:0], 1'b1, 8, 1'b1, 1'b0, mo, mi, lat, oeb);
            n_checks++;
            if (mi[0] !== 8'h5A) begin n_fail++; $display("FAIL mode%0d_miso: got %h exp 5a", m, mi[0]); end
            n_checks++;
            if (rx_cnt - r0 != 1 || rx_mem[r0 % 16] !== 8'hC3) begin
                n_fail++; $display("FAIL mode%0d_rx: got %0d pushes %h exp 1 push c3", m, rx_cnt - r0, rx_mem[r0 % 16]);
            end
            flush_fifo();
        end
    endtask

    task automatic test_underrun();
        logic [7:0] mo [4];
        logic [7:0] mi [4];
        int p0, u0, r0, lat, oeb;
        mo = '{8'h00, 8'h00, 8'h00, 8'h00};
        mo[0] = 8'($urandom);
        p0 = pop_cnt; u0 = und_cnt; r0 = rx_cnt;
        spi_xfer(2'b00, 1'b1, 8, 1'b1, 1'b0, mo, mi, lat, oeb);
        n_checks++;
        if (mi[0] !== 8'hFF) begin n_fail++; $display("FAIL und_miso: got %h exp ff", mi[0]); end
        n_checks++;
        if (pop_cnt - p0 != 0) begin n_fail++; $display("FAIL und_pops: got %0d exp 0", pop_cnt - p0); end
        n_checks++;
        if (und_cnt - u0 != 2) begin n_fail++; $display("FAIL und_pulses: got %0d exp 2", und_cnt - u0); end
        n_checks++;
        if (rx_cnt - r0 != 1 || rx_mem[r0 % 16] !== mo[0]) begin
            n_fail++; $display("FAIL und_rx: got %0d pushes %h exp 1 push %h", rx_cnt - r0, rx_mem[r0 % 16], mo[0]);
        end
    endtask

    task automatic test_abort();
        logic [7:0] txb [4];
        logic [7:0] mo [4];
        logic [7:0] mi [4];
        int p0, r0, lat, oeb;
        txb = '{8'h96, 8'h69, 8'h00, 8'h00};
        mo  = '{8'hE7, 8'h00, 8'h00, 8'h00};
        load_fifo(2, txb);
        p0 = pop_cnt; r0 = rx_cnt;
        spi_xfer(2'b00, 1'b1, 5, 1'b1, 1'b0, mo, mi, lat, oeb);
        n_checks++;
        if (rx_cnt - r0 != 0) begin n_fail++; $display("FAIL abort_rx: got %0d pushes exp 0", rx_cnt - r0); end
        n_checks++;
        if (pop_cnt - p0 != 1) begin n_fail++; $display("FAIL abort_pops: got %0d exp 1", pop_cnt - p0); end
        n_checks++;
        if ({busy_o, spi_dq1_oe_o} !== 2'b00) begin
            n_fail++; $display("FAIL abort_idle: got busy=%b oe=%b exp 0 0", busy_o, spi_dq1_oe_o);
        end
        flush_fifo();
        txb = '{8'h3B, 8'h00, 8'h00, 8'h00};
        mo  = '{8'h4D, 8'h00, 8'h00, 8'h00};
        load_fifo(1, txb);
        r0 = rx_cnt;
        spi_xfer(2'b10, 1'b0, 8, 1'b1, 1'b0, mo, mi, lat, oeb);
        n_checks++;
        if (mi[0] !== 8'h3B || rx_cnt - r0 != 1 || rx_mem[r0 % 16] !== 8'h4D) begin
            n_fail++; $display("FAIL after_abort: miso %h rx %0d pushes %h, exp miso 3b and 1 push 4d",
                               mi[0], rx_cnt - r0, rx_mem[r0 % 16]);
        end
        flush_fifo();
    endtask

    task automatic test_reset_mid();
        logic [7:0] txb [4];
        logic [7:0] mo [4];
        logic [7:0] mi [4];
        int p0, r0, u0, lat, oeb;
        txb = '{8'hC6, 8'h00, 8'h00, 8'h00};
        mo  = '{8'hB1, 8'h00, 8'h00, 8'h00};
        load_fifo(1, txb);
        spi_xfer(2'b01, 1'b1, 4, 1'b1, 1'b1, mo, mi, lat, oeb);
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, spi_dq1_oe_o, spi_dq1_o, fifo.tx_pop_o, fifo.rx_valid_o, underrun_o, fifo.rx_data_o} !== 14'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy=%b oe=%b dq1=%b pop=%b rxv=%b und=%b rxd=%h, exp all 0",
                     busy_o, spi_dq1_oe_o, spi_dq1_o, fifo.tx_pop_o, fifo.rx_valid_o, underrun_o, fifo.rx_data_o);
        end
        flush_fifo();
        load_fifo(1, txb);
        p0 = pop_cnt; r0 = rx_cnt; u0 = und_cnt;
        rst_ni = 1'b1;
        repeat (20) @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0 || pop_cnt != p0 || rx_cnt != r0 || und_cnt != u0) begin
            n_fail++; $display("FAIL ss_low_at_release: busy=%b pops=%0d pushes=%0d und=%0d, exp no start",
                               busy_o, pop_cnt - p0, rx_cnt - r0, und_cnt - u0);
        end
        spi_ss_i = 1'b1;
        repeat (6) @(negedge clk_i);
        r0 = rx_cnt;
        spi_xfer(2'b00, 1'b1, 8, 1'b1, 1'b0, mo, mi, lat, oeb);
        n_checks++;
        if (mi[0] !== 8'hC6 || rx_cnt - r0 != 1 || rx_mem[r0 % 16] !== 8'hB1) begin
            n_fail++; $display("FAIL after_reset: miso %h rx %0d pushes %h, exp miso c6 and 1 push b1",
                               mi[0], rx_cnt - r0, rx_mem[r0 % 16]);
        end
        flush_fifo();
    endtask

    task automatic test_enable();
        logic [7:0] txb [4];
        logic [7:0] mo [4];
        logic [7:0] mi [4];
        int p0, r0, u0, lat, oeb;
        txb = '{8'h77, 8'h00, 8'h00, 8'h00};
        mo  = '{8'h1E, 8'h00, 8'h00, 8'h00};
        load_fifo(1, txb);
        @(negedge clk_i);
        enable_i = 1'b0;
        p0 = pop_cnt; r0 = rx_cnt; u0 = und_cnt;
        spi_xfer(2'b00, 1'b1, 8, 1'b0, 1'b0, mo, mi, lat, oeb);
        n_checks++;
        if (pop_cnt != p0 || rx_cnt != r0 || und_cnt != u0) begin
            n_fail++; $display("FAIL disabled_activity: pops=%0d pushes=%0d und=%0d exp 0 0 0",
                               pop_cnt - p0, rx_cnt - r0, und_cnt - u0);
        end
        n_checks++;
        if (oeb != 0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL disabled_oe: got %0d oe samples high busy=%b exp 0 0", oeb, busy_o);
        end
        enable_i = 1'b1;
        repeat (6) @(negedge clk_i);
        r0 = rx_cnt;
        spi_xfer(2'b00, 1'b1, 3, 1'b1, 1'b1, mo, mi, lat, oeb);
        enable_i = 1'b0;
        repeat (4) @(negedge clk_i);
        n_checks++;
        if ({busy_o, spi_dq1_oe_o} !== 2'b00 || rx_cnt != r0) begin
            n_fail++; $display("FAIL enable_abort: busy=%b oe=%b pushes=%0d exp 0 0 0",
                               busy_o, spi_dq1_oe_o, rx_cnt - r0);
        end
        spi_ss_i = 1'b1;
        repeat (6) @(negedge clk_i);
        enable_i = 1'b1;
        repeat (6) @(negedge clk_i);
        flush_fifo();
    endtask

    task automatic test_random();
        logic [7:0] txb [4];
        logic [7:0] mo [4];
        logic [7:0] mi [4];
        int p0, u0, r0, lat, oeb, nb, fill, ep;
        logic [1:0] mode;
        logic msb;
        for (int it = 0; it < 8; it++) begin
            mode = 2'($urandom_range(0, 3));
            msb  = 1'($urandom_range(0, 1));
            nb   = $urandom_range(1, 3);
            fill = $urandom_range(0, nb + 1);
            for (int k = 0; k < 4; k++) begin
                txb[k] = 8'($urandom);
                mo[k]  = 8'($urandom);
            end
            load_fifo(fill, txb);
            p0 = pop_cnt; u0 = und_cnt; r0 = rx_cnt;
            spi_xfer(mode, msb, nb * 8, 1'b1, 1'b0, mo, mi, lat, oeb);
            for (int k = 0; k < nb; k++) begin
                n_checks++;
                if (mi[k] !== exp_miso(k, fill, txb)) begin
                    n_fail++; $display("FAIL rnd%0d_miso%0d: got %h exp %h (mode %0d msb %b)",
                                       it, k, mi[k], exp_miso(k, fill, txb), mode, msb);
                end
                n_checks++;
                if (rx_mem[(r0 + k) % 16] !== mo[k]) begin
                    n_fail++; $display("FAIL rnd%0d_rx%0d: got %h exp %h", it, k, rx_mem[(r0 + k) % 16], mo[k]);
                end
            end
            ep = (fill < nb + 1) ? fill : nb + 1;
            n_checks++;
            if (rx_cnt - r0 != nb || pop_cnt - p0 != ep || und_cnt - u0 != nb + 1 - ep) begin
                n_fail++; $display("FAIL rnd%0d_counts: pushes %0d pops %0d und %0d exp %0d %0d %0d",
                                   it, rx_cnt - r0, pop_cnt - p0, und_cnt - u0, nb, ep, nb + 1 - ep);
            end
            flush_fifo();
        end
    endtask

    initial begin
        fifo.tx_data_i  = 8'h00;
        fifo.tx_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        test_reset();
        test_mode0_basic();
        test_mode3_back_to_back();
        test_modes_1_2();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_enable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Single-lane (standard) SPI slave engine for the `role_mode=1` path of the SPI peripheral.
- Sits between the pin mux and the peripheral's TX/RX byte FIFOs:
  - pops TX FIFO bytes and serialises them onto MISO (`dq1`);
  - deserialises MOSI (`dq0`) into bytes and pushes them to the RX FIFO.
- Oversamples the external SCLK/SS/MOSI with `clk_i`. All logic is in the `clk_i` domain.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on `spi_clk_i`, `spi_ss_i`, `spi_dq0_i` (legal 2..3).

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset. One clock; reset is asynchronous and active-low.
- enable_i  input  1  slave enabled; when 0, SS is ignored and outputs stay at reset values.
- cp_mode_i  input  2  [1]=CPOL, [0]=CPHA; must be stable while busy_o=1.
- msb_first_i  input  1  1: bit7 first, 0: bit0 first; stable while busy_o=1.
- tx_data_i  input  8  head of TX FIFO.
- tx_valid_i  input  1  TX FIFO not empty.
- tx_pop_o  output  1  one-cycle pulse; consumes tx_data_i.
- rx_data_o  output  8  received byte, valid with rx_valid_o.
- rx_valid_o  output  1  one-cycle push pulse to RX FIFO.
- underrun_o  output  1  one-cycle pulse; byte load found TX FIFO empty.
- busy_o  output  1  1 while selected (state != IDLE).
- spi_clk_i  input  1  external SCLK.
- spi_ss_i  input  1  external chip select, active low.
- spi_dq0_i  input  1  MOSI.
- spi_dq1_o  output  1  MISO data.
- spi_dq1_oe_o  output  1  MISO output enable.

Behaviour:
- Reset values: all outputs 0; state IDLE; shift regs 0; bit_cnt 0; synchroniser flops reset to 1 for SS, 0 for others.
- Synchronisers: SYNC_STAGES flops, then one extra flop on SCLK and SS for edge detection.
  - lead_edge = rising if CPOL=0, falling if CPOL=1; trail_edge is the opposite.
  - sample_edge = CPHA ? trail_edge : lead_edge.
  - shift_edge = CPHA ? lead_edge : trail_edge.
- Max supported SCLK: `clk_i`/8. SS-fall to first SCLK edge must be at least 4 `clk_i` cycles.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE:
  - Transition: synced SS falling edge and enable_i=1 -> LOAD.
  - SS low at reset release or enable rise is not a start; a fresh falling edge is required.
- LOAD (one cycle):
  - If tx_valid_i: tx_shreg <= tx_data_i, tx_pop_o=1.
  - Else: tx_shreg <= 8'hFF, underrun_o=1.
  - bit_cnt <= 0; go to SHIFT.
- SHIFT, on sample_edge:
  - rx_shreg takes synced MOSI. msb_first: shift left, insert at bit0. Else: shift right, insert at bit7.
  - bit_cnt increments mod 8.
  - When bit_cnt was 7:
    - next cycle rx_data_o=assembled byte and rx_valid_o=1;
    - same cycle state -> LOAD (reload next TX byte);
    - bit_cnt wraps to 0.
- SHIFT, on shift_edge:
  - tx_shreg shifts (left if msb_first, else right; fill 1) only when bit_cnt != 0.
  - Uniform rule for both CPHA values: the first bit of each byte is presented from LOAD until the first qualifying shift.
- MISO:
  - spi_dq1_o = msb_first ? tx_shreg[7] : tx_shreg[0].
  - spi_dq1_oe_o = 1 in LOAD/SHIFT, 0 in IDLE.
  - Output is combinational from the register (no extra delay).
- rx_valid_o is pulsed regardless of downstream FIFO state; overflow is the FIFO/core's concern.
- SS synced rise in any state -> IDLE next cycle:
  - partial byte discarded, no rx_valid_o, bit_cnt=0;
  - a TX byte already popped is lost (no push-back).
- enable_i falling while busy: same as SS rise (abort to IDLE).
- SCLK edge in the same cycle as SS rise: SS wins, edge ignored.
- An SCLK edge while in LOAD cannot occur under the timing constraint; if it does, it is ignored.
- Asynchronous reset mid-transfer: immediate return to reset values.

Test Plan:
- Mode 0, msb_first=1, TX FIFO holds 8'hA5. Master sends 8'h3C with SS low for 8 clocks. -> Master receives 8'hA5; rx_valid_o one pulse with 8'h3C; tx_pop_o exactly one pulse; busy_o falls 2–3 clk after SS rise.
- Mode 3, msb_first=0, TX holds 8'h01, 8'h80. Master sends 8'hF0, 8'h0F back-to-back under one SS. -> Master reads 8'h01 then 8'h80; two rx_valid_o pulses with 8'hF0, 8'h0F; two tx_pop_o pulses.
- Modes 1 and 2, TX 8'h5A, MOSI 8'hC3. -> Bytes match in both directions for each mode.
- TX FIFO empty at SS fall. -> underrun_o pulse, no tx_pop_o, master reads 8'hFF, RX still captures the MOSI byte.
- SS rises after 5 SCLK cycles. -> No rx_valid_o, state IDLE, oe=0; next full transfer is correct with bit_cnt starting at 0.
- rst_ni asserted mid-byte, and separately enable_i=0 while SS toggles. -> All outputs 0, no pops or pushes.
